// File: rtl/audio_i2s_out.sv
// audio_i2s_out
//   Final stage of the FM receive chain. Pops the gain_left/gain_right FIFOs
//   in lockstep once per frame, rescales each 32-bit fixed-point word to a
//   saturated SAMPLE_WIDTH-bit sample and serialises the pair as an I2S
//   stream. When either FIFO is empty at a frame boundary, neither FIFO is
//   popped and an all-zero frame is sent instead.
//
// Ports
//   clock, reset              system clock, asynchronous active-high reset
//   left_din/left_empty       gain_left FIFO head word (FWFT) and empty flag
//   left_rd_en                pop strobe for gain_left
//   right_din/right_empty     gain_right FIFO head word (FWFT) and empty flag
//   right_rd_en               pop strobe for gain_right
//   i2s_bclk                  bit clock, free-running, starts low
//   i2s_lrclk                 word select (0 = left, 1 = right)
//   i2s_sdata                 serial data, MSB first, changes on bclk fall
//   underrun                  one-cycle pulse when a zero frame is loaded
module audio_i2s_out #(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SHIFT        = 10,
  parameter int BCLK_DIV     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] left_din,
  input  logic                  left_empty,
  output logic                  left_rd_en,
  input  logic [DATA_WIDTH-1:0] right_din,
  input  logic                  right_empty,
  output logic                  right_rd_en,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  underrun
);

  localparam int FRAME_BITS = 2 * SAMPLE_WIDTH;
  localparam int DIV_W      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int IDX_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_REQ  = DIV_W'(BCLK_DIV - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] LR_FIRST = IDX_W'(SAMPLE_WIDTH - 1);
  localparam logic [IDX_W-1:0] LR_LAST  = IDX_W'(FRAME_BITS - 2);

  // Saturation limits of a SAMPLE_WIDTH-bit signed sample, held at DATA_WIDTH
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
    {{(DATA_WIDTH-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN =
    {{(DATA_WIDTH-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  logic [0:0]            r_state;
  logic [DIV_W-1:0]      r_div_cnt;
  logic                  r_bclk;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [FRAME_BITS-1:0] r_shreg;
  logic                  r_sdata;
  logic                  r_lrclk;

  logic                    w_div_wrap;
  logic                    w_fall;
  logic                    w_req;
  logic                    w_avail;
  logic [IDX_W-1:0]        w_next_idx;
  logic                    w_next_lr;
  logic [SAMPLE_WIDTH-1:0] w_left_fmt;
  logic [SAMPLE_WIDTH-1:0] w_right_fmt;

  function automatic logic [SAMPLE_WIDTH-1:0] sat_fmt(input logic [DATA_WIDTH-1:0] din);
    logic signed [DATA_WIDTH-1:0] x;
    x = $signed(din) >>> SHIFT;
    if (x > SAT_MAX)
      sat_fmt = SAT_MAX[SAMPLE_WIDTH-1:0];
    else if (x < SAT_MIN)
      sat_fmt = SAT_MIN[SAMPLE_WIDTH-1:0];
    else
      sat_fmt = x[SAMPLE_WIDTH-1:0];
  endfunction

  always_comb begin
    w_div_wrap  = (r_div_cnt == DIV_LAST);
    w_fall      = w_div_wrap && r_bclk;
    // Request sits one cycle ahead of the fall that emits bit 0, so the frame
    // register is loaded just before its MSB is needed.
    w_req       = (r_state == ST_FRAME) && r_bclk && (r_div_cnt == DIV_REQ) &&
                  (r_bit_idx == IDX_LAST);
    w_avail     = !left_empty && !right_empty;
    w_next_idx  = (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + 1'b1;
    w_next_lr   = (w_next_idx >= LR_FIRST) && (w_next_idx <= LR_LAST);
    w_left_fmt  = sat_fmt(left_din);
    w_right_fmt = sat_fmt(right_din);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_bit_idx <= IDX_LAST;
      r_shreg   <= '0;
      r_sdata   <= 1'b0;
      r_lrclk   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= ST_FRAME;
        default:  r_state <= ST_FRAME;
      endcase

      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
      if (w_div_wrap)
        r_bclk <= ~r_bclk;

      // Request and fall fall on different div_cnt values, so they never collide
      if (w_req) begin
        r_shreg <= w_avail ? {w_left_fmt, w_right_fmt} : '0;
      end else if (w_fall) begin
        r_sdata   <= r_shreg[FRAME_BITS-1];
        r_shreg   <= {r_shreg[FRAME_BITS-2:0], 1'b0};
        r_bit_idx <= w_next_idx;
        r_lrclk   <= w_next_lr;
      end
    end
  end

  assign left_rd_en  = w_req && w_avail;
  assign right_rd_en = w_req && w_avail;
  assign underrun    = w_req && !w_avail;
  assign i2s_bclk    = r_bclk;
  assign i2s_lrclk   = r_lrclk;
  assign i2s_sdata   = r_sdata;

endmodule

// File: tb/tb_audio_i2s_out.sv
module tb_audio_i2s_out;

  localparam int DW = 32;
  localparam int W  = 16;
  localparam int SH = 10;
  localparam int D  = 4;
  localparam int FB = 2 * W;
  localparam int FR = FB * 2 * D;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] left_din = '0;
  logic [DW-1:0] right_din = '0;
  logic          left_empty = 1'b1;
  logic          right_empty = 1'b1;
  logic          left_rd_en, right_rd_en;
  logic          i2s_bclk, i2s_lrclk, i2s_sdata, underrun;
  logic [5:0]    obs;

  int compared = 0;
  int failed   = 0;
  int n        = 0;

  logic [DW-1:0] lq[$];
  logic [DW-1:0] rq[$];
  logic [FB-1:0] frames[64];

  audio_i2s_out #(
    .DATA_WIDTH(DW),
    .SAMPLE_WIDTH(W),
    .SHIFT(SH),
    .BCLK_DIV(D)
  ) dut (
    .clock(clock),
    .reset(reset),
    .left_din(left_din),
    .left_empty(left_empty),
    .left_rd_en(left_rd_en),
    .right_din(right_din),
    .right_empty(right_empty),
    .right_rd_en(right_rd_en),
    .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata),
    .underrun(underrun)
  );

  always #5 clock = ~clock;

  assign obs = {i2s_bclk, i2s_lrclk, i2s_sdata, left_rd_en, right_rd_en, underrun};

  // clock edges since reset release
  always @(posedge clock or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  // Reference formatting: floor-divide by 2^SH, then clamp to W-bit signed range
  function automatic logic [W-1:0] sat(input logic [DW-1:0] din);
    longint v, x, q;
    v = longint'($signed(din));
    q = longint'(1) << SH;
    x = (v >= 0) ? v / q : -((-v + q - 1) / q);
    if (x > 32767) x = 32767;
    else if (x < -32768) x = -32768;
    return x[W-1:0];
  endfunction

  // Expected {bclk, lrclk, sdata, left_rd_en, right_rd_en, underrun} after t edges
  function automatic logic [5:0] exp_vec(input int t);
    int f, k, j;
    logic bc, lr, sd, req, ok;
    bc = ((t / D) % 2) == 1;
    f  = t / (2 * D);
    lr = 1'b0;
    sd = 1'b0;
    if (f > 0) begin
      k  = (f - 1) % FB;
      j  = ((f - 1) / FB) % 64;
      sd = frames[j][FB-1-k];
      lr = (k >= W - 1) && (k <= FB - 2);
    end
    req = (t > 0) && ((t % FR) == 2 * D - 2);
    ok  = (lq.size() > 0) && (rq.size() > 0);
    return {bc, lr, sd, req && ok, req && ok, req && !ok};
  endfunction

  // Frame contents decided at each frame boundary from the FIFO model
  always @(negedge clock) begin
    if (!reset && n > 0 && (n % FR) == 2 * D - 2)
      frames[(n / FR) % 64] <= (lq.size() > 0 && rq.size() > 0) ?
                               {sat(lq[0]), sat(rq[0])} : '0;
  end

  // FWFT FIFO model: pops take effect just after the edge that consumed the head
  initial begin
    logic pl, pr;
    forever begin
      @(negedge clock);
      pl = left_rd_en;
      pr = right_rd_en;
      @(posedge clock);
      #1;
      if (pl && lq.size() > 0) void'(lq.pop_front());
      if (pr && rq.size() > 0) void'(rq.pop_front());
      left_empty  = (lq.size() == 0);
      left_din    = left_empty ? '0 : lq[0];
      right_empty = (rq.size() == 0);
      right_din   = right_empty ? '0 : rq[0];
    end
  end

  function automatic logic [DW-1:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 0) return r;
    return {{12{r[19]}}, r[19:0]};
  endfunction

  task automatic wait_phase(input int ph);
    for (int i = 0; i < FR + 1; i++) begin
      @(negedge clock);
      if ((n % FR) == ph) break;
    end
  endtask

  task automatic test_reset();
    int first_rise, first_fall, first_und, unds;
    logic prev;
    logic [5:0] e;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      compared++;
      if (obs !== 6'b0) begin failed++; $display("FAIL reset_outputs got %b want 000000", obs); end
    end
    reset = 1'b0;
    first_rise = -1; first_fall = -1; first_und = -1; unds = 0; prev = 1'b0;
    repeat (3 * FR) begin
      @(negedge clock);
      e = exp_vec(n);
      compared++;
      if (obs !== e) begin failed++; $display("FAIL reset_cycle n=%0d got %b want %b", n, obs, e); end
      if (first_rise < 0 && i2s_bclk) first_rise = n;
      if (first_fall < 0 && prev && !i2s_bclk) first_fall = n;
      if (first_und < 0 && underrun) first_und = n;
      if (underrun) unds++;
      prev = i2s_bclk;
    end
    compared++;
    if (first_rise != D) begin failed++; $display("FAIL first_rise got %0d want %0d", first_rise, D); end
    compared++;
    if (first_fall != 2 * D) begin failed++; $display("FAIL first_fall got %0d want %0d", first_fall, 2 * D); end
    compared++;
    if (first_und != 2 * D - 2) begin failed++; $display("FAIL first_underrun got %0d want %0d", first_und, 2 * D - 2); end
    compared++;
    if (unds != 3) begin failed++; $display("FAIL reset_underrun_count got %0d want 3", unds); end
  endtask

  task automatic test_format(input string name, input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input logic [FB-1:0] exp_word);
    int pops, nb;
    logic cap, prev;
    logic [FB-1:0] word, lrw;
    logic [5:0] e;
    wait_phase(128);
    #2;
    lq.push_back(l);
    rq.push_back(r);
    pops = 0; nb = 0; cap = 1'b0; prev = 1'b0; word = '0; lrw = '0;
    repeat (2 * FR) begin
      @(negedge clock);
      e = exp_vec(n);
      compared++;
      if (obs !== e) begin failed++; $display("FAIL %s_cycle n=%0d got %b want %b", name, n, obs, e); end
      if (left_rd_en) begin pops++; cap = 1'b1; nb = 0; end
      if (cap && nb < FB && i2s_bclk && !prev) begin
        word = {word[FB-2:0], i2s_sdata};
        lrw  = {lrw[FB-2:0], i2s_lrclk};
        nb++;
      end
      prev = i2s_bclk;
    end
    compared++;
    if (word !== exp_word) begin failed++; $display("FAIL %s_word got %h want %h", name, word, exp_word); end
    compared++;
    if (lrw !== 32'h0001FFFE) begin failed++; $display("FAIL %s_lrclk got %h want 0001fffe", name, lrw); end
    compared++;
    if (pops != 1) begin failed++; $display("FAIL %s_pops got %0d want 1", name, pops); end
  endtask

  task automatic test_one_sided();
    int pops, unds;
    logic [5:0] e;
    wait_phase(128);
    #2;
    lq.push_back(rand_word());
    lq.push_back(rand_word());
    pops = 0; unds = 0;
    repeat (3 * FR) begin
      @(negedge clock);
      e = exp_vec(n);
      compared++;
      if (obs !== e) begin failed++; $display("FAIL onesided_cycle n=%0d got %b want %b", n, obs, e); end
      if (left_rd_en || right_rd_en) pops++;
      if (underrun) unds++;
    end
    compared++;
    if (pops != 0) begin failed++; $display("FAIL onesided_pops got %0d want 0", pops); end
    compared++;
    if (unds != 3) begin failed++; $display("FAIL onesided_underruns got %0d want 3", unds); end
    compared++;
    if (lq.size() != 2) begin failed++; $display("FAIL onesided_left_count got %0d want 2", lq.size()); end
    // still at phase 128 here: add the missing channel and expect pops to resume
    #2;
    rq.push_back(rand_word());
    rq.push_back(rand_word());
    pops = 0; unds = 0;
    repeat (2 * FR) begin
      @(negedge clock);
      e = exp_vec(n);
      compared++;
      if (obs !== e) begin failed++; $display("FAIL resume_cycle n=%0d got %b want %b", n, obs, e); end
      if (left_rd_en && right_rd_en) pops++;
      if (underrun) unds++;
    end
    compared++;
    if (pops != 2 || unds != 0) begin
      failed++; $display("FAIL resume_pops got %0d/%0d want 2/0", pops, unds);
    end
    compared++;
    if (lq.size() != 0 || rq.size() != 0) begin
      failed++; $display("FAIL resume_drain got %0d/%0d want 0/0", lq.size(), rq.size());
    end
  endtask

  task automatic test_back_to_back();
    int pops, unds, last_pop, last_lr;
    logic prev_lr;
    logic [5:0] e;
    wait_phase(128);
    #2;
    repeat (3) begin
      lq.push_back(rand_word());
      rq.push_back(rand_word());
    end
    pops = 0; unds = 0; last_pop = -1; last_lr = -1; prev_lr = i2s_lrclk;
    repeat (4 * FR) begin
      @(negedge clock);
      e = exp_vec(n);
      compared++;
      if (obs !== e) begin failed++; $display("FAIL b2b_cycle n=%0d got %b want %b", n, obs, e); end
      if (left_rd_en) begin
        if (last_pop >= 0) begin
          compared++;
          if (n - last_pop != FR) begin failed++; $display("FAIL b2b_pop_spacing got %0d want %0d", n - last_pop, FR); end
        end
        last_pop = n;
        pops++;
      end
      if (i2s_lrclk && !prev_lr) begin
        if (last_lr >= 0) begin
          compared++;
          if (n - last_lr != FR) begin failed++; $display("FAIL b2b_lrclk_period got %0d want %0d", n - last_lr, FR); end
        end
        last_lr = n;
      end
      prev_lr = i2s_lrclk;
      if (underrun) unds++;
    end
    compared++;
    if (pops != 3) begin failed++; $display("FAIL b2b_pops got %0d want 3", pops); end
    compared++;
    if (unds != 1) begin failed++; $display("FAIL b2b_underruns got %0d want 1", unds); end
  endtask

  task automatic test_mid_reset();
    int pops, unds, first_pop, nb;
    logic found, cap, prev;
    logic [DW-1:0] l2, r2;
    logic [FB-1:0] word;
    logic [5:0] e;
    l2 = rand_word();
    r2 = rand_word();
    wait_phase(128);
    #2;
    lq.push_back(rand_word());
    rq.push_back(rand_word());
    lq.push_back(l2);
    rq.push_back(r2);
    found = 1'b0;
    for (int i = 0; i < FR + 2; i++) begin
      @(negedge clock);
      if (left_rd_en) begin found = 1'b1; break; end
    end
    compared++;
    if (!found) begin failed++; $display("FAIL midreset_pop_timeout got no pop want pop"); end
    // bit index 10 is emitted by the fall 88 edges into the frame period
    wait_phase(90);
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (obs !== 6'b0) begin failed++; $display("FAIL midreset_immediate got %b want 000000", obs); end
    repeat (3) begin
      @(negedge clock);
      compared++;
      if (obs !== 6'b0) begin failed++; $display("FAIL midreset_hold got %b want 000000", obs); end
    end
    reset = 1'b0;
    pops = 0; unds = 0; first_pop = -1; nb = 0; cap = 1'b0; prev = 1'b0; word = '0;
    repeat (2 * FR) begin
      @(negedge clock);
      e = exp_vec(n);
      compared++;
      if (obs !== e) begin failed++; $display("FAIL midreset_cycle n=%0d got %b want %b", n, obs, e); end
      if (left_rd_en) begin
        if (first_pop < 0) first_pop = n;
        pops++;
        cap = (pops == 1);
      end
      if (cap && nb < FB && i2s_bclk && !prev) begin word = {word[FB-2:0], i2s_sdata}; nb++; end
      prev = i2s_bclk;
      if (underrun) unds++;
    end
    compared++;
    if (first_pop != 2 * D - 2) begin failed++; $display("FAIL midreset_first_pop got %0d want %0d", first_pop, 2 * D - 2); end
    compared++;
    if (pops != 1 || unds != 1) begin failed++; $display("FAIL midreset_counts got %0d/%0d want 1/1", pops, unds); end
    compared++;
    if (word !== {sat(l2), sat(r2)}) begin
      failed++; $display("FAIL midreset_word got %h want %h", word, {sat(l2), sat(r2)});
    end
  endtask

  initial begin
    logic [DW-1:0] rl, rr;
    test_reset();
    test_format("basic", 32'h00040000, 32'hFFFFFC00, 32'h0100FFFF);
    test_format("saturate", 32'h7FFFFFFF, 32'h80000000, 32'h7FFF8000);
    rl = rand_word();
    rr = rand_word();
    test_format("random", rl, rr, {sat(rl), sat(rr)});
    test_one_sided();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached want completion");
    $fatal(1, "watchdog");
  end

endmodule
